// File: rtl/mul_arb_pkg.sv
// Shared constants for the multiplier job arbiter: FSM encodings and default sizing.
package mul_arb_pkg;

    localparam int unsigned ARB_W_DEFAULT       = 32;
    localparam int unsigned ARB_TIMEOUT_DEFAULT = 20;

    localparam int unsigned ST_W = 2;

    localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [ST_W-1:0] ST_ISSUE = 2'd1;
    localparam logic [ST_W-1:0] ST_WAIT  = 2'd2;
    localparam logic [ST_W-1:0] ST_RESP  = 2'd3;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
    parameter int unsigned N = 2,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] id_c,
    output logic          any_c
);

    int unsigned sum;

    always_comb begin
        id_c  = '0;
        any_c = 1'b0;
        sum   = 0;
        for (int unsigned i = 0; i < N; i++) begin
            sum = 32'(ptr) + i;
            if (sum >= N) begin
                sum = sum - N;
            end
            if (!any_c && req[IW'(sum)]) begin
                any_c = 1'b1;
                id_c  = IW'(sum);
            end
        end
    end

endmodule

// File: rtl/mul_job_arbiter.sv
// Round-robin front end sharing one multiplier engine among N_REQ requesters,
// with timeout/abort recovery so no requester waits forever.
module mul_job_arbiter
    import mul_arb_pkg::*;
#(
    parameter int unsigned N_REQ   = 2,
    parameter int unsigned W       = ARB_W_DEFAULT,
    parameter int unsigned TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    input  logic               abort,
    output logic [N_REQ-1:0]   ack,
    output logic [N_REQ-1:0]   rsp_valid,
    output logic [2*W-1:0]     rsp_result,
    output logic               rsp_err,
    output logic               eng_op_start,
    output logic               eng_op_clear,
    output logic [W-1:0]       eng_a,
    output logic [W-1:0]       eng_b,
    input  logic               eng_done,
    input  logic [2*W-1:0]     eng_result
);

    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT);

    logic [ST_W-1:0]  state, state_nxt;
    logic [IW-1:0]    rr_ptr, rr_ptr_nxt;
    logic [IW-1:0]    id, id_nxt;
    logic [TW-1:0]    timer, timer_nxt;
    logic [W-1:0]     eng_a_nxt, eng_b_nxt;
    logic [N_REQ-1:0] ack_nxt, rsp_valid_nxt;
    logic [2*W-1:0]   rsp_result_nxt;
    logic             rsp_err_nxt, eng_op_start_nxt, eng_op_clear_nxt;

    logic [IW-1:0]    pick_id;
    logic             pick_any;
    logic [W-1:0]     a_sel, b_sel;

    rr_pick #(.N(N_REQ)) u_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .id_c  (pick_id),
        .any_c (pick_any)
    );

    // Operand mux for the requester the picker selected this cycle.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (pick_id == IW'(i)) begin
                a_sel = req_a[i*W +: W];
                b_sel = req_b[i*W +: W];
            end
        end
    end

    // Next state; outputs are decoded for the state being entered so they register with it.
    always_comb begin
        state_nxt        = state;
        rr_ptr_nxt       = rr_ptr;
        id_nxt           = id;
        timer_nxt        = timer;
        eng_a_nxt        = eng_a;
        eng_b_nxt        = eng_b;
        ack_nxt          = '0;
        rsp_valid_nxt    = '0;
        rsp_result_nxt   = '0;
        rsp_err_nxt      = 1'b0;
        eng_op_start_nxt = 1'b0;
        eng_op_clear_nxt = 1'b0;

        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    id_nxt           = pick_id;
                    eng_a_nxt        = a_sel;
                    eng_b_nxt        = b_sel;
                    ack_nxt          = N_REQ'(1) << pick_id;
                    eng_op_start_nxt = 1'b1;
                    state_nxt        = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                timer_nxt = '0;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // Done takes priority over a same-cycle abort or timeout.
                if (eng_done) begin
                    rsp_valid_nxt    = N_REQ'(1) << id;
                    rsp_result_nxt   = eng_result;
                    eng_op_clear_nxt = 1'b1;
                    state_nxt        = ST_RESP;
                end else if (abort || (timer == TW'(TIMEOUT - 1))) begin
                    rsp_valid_nxt    = N_REQ'(1) << id;
                    rsp_err_nxt      = 1'b1;
                    eng_op_clear_nxt = 1'b1;
                    state_nxt        = ST_RESP;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            ST_RESP: begin
                rr_ptr_nxt = (id == IW'(N_REQ - 1)) ? '0 : id + IW'(1);
                state_nxt  = ST_IDLE;
            end
            default: begin
                eng_a_nxt = '0;
                eng_b_nxt = '0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            rr_ptr       <= '0;
            id           <= '0;
            timer        <= '0;
            eng_a        <= '0;
            eng_b        <= '0;
            ack          <= '0;
            rsp_valid    <= '0;
            rsp_result   <= '0;
            rsp_err      <= 1'b0;
            eng_op_start <= 1'b0;
            eng_op_clear <= 1'b0;
        end else begin
            state        <= state_nxt;
            rr_ptr       <= rr_ptr_nxt;
            id           <= id_nxt;
            timer        <= timer_nxt;
            eng_a        <= eng_a_nxt;
            eng_b        <= eng_b_nxt;
            ack          <= ack_nxt;
            rsp_valid    <= rsp_valid_nxt;
            rsp_result   <= rsp_result_nxt;
            rsp_err      <= rsp_err_nxt;
            eng_op_start <= eng_op_start_nxt;
            eng_op_clear <= eng_op_clear_nxt;
        end
    end

endmodule

// File: tb/tb_mul_job_arbiter.sv
// Scoreboard bench for mul_job_arbiter with a behavioural 16-cycle multiplier engine.
module tb_mul_job_arbiter;

    localparam int unsigned N_REQ   = 2;
    localparam int unsigned W       = 32;
    localparam int unsigned TIMEOUT = 20;

    typedef struct packed {
        logic [1:0]  who;
        logic [63:0] res;
        logic        err;
        logic [31:0] a;
        logic [31:0] b;
    } rsp_t;

    logic               clk = 1'b0;
    logic               reset;
    logic [N_REQ-1:0]   req;
    logic [N_REQ*W-1:0] req_a, req_b;
    logic               abort;
    logic [N_REQ-1:0]   ack, rsp_valid;
    logic [2*W-1:0]     rsp_result;
    logic               rsp_err, eng_op_start, eng_op_clear;
    logic [W-1:0]       eng_a, eng_b;
    logic               eng_done;
    logic [2*W-1:0]     eng_result;

    logic               hang;
    logic               busy;
    logic [4:0]         cnt;

    int   vectors     = 0;
    int   miscompares = 0;
    rsp_t rsp_q[$];
    logic [1:0] ack_q[$];
    rsp_t mon_e;
    logic [1:0] mon_ack;

    mul_job_arbiter #(.N_REQ(N_REQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_a        (req_a),
        .req_b        (req_b),
        .abort        (abort),
        .ack          (ack),
        .rsp_valid    (rsp_valid),
        .rsp_result   (rsp_result),
        .rsp_err      (rsp_err),
        .eng_op_start (eng_op_start),
        .eng_op_clear (eng_op_clear),
        .eng_a        (eng_a),
        .eng_b        (eng_b),
        .eng_done     (eng_done),
        .eng_result   (eng_result)
    );

    always #5 clk = ~clk;

    // Engine: DONE 16 cycles after op_start, held until op_clear; hang suppresses DONE.
    always @(posedge clk) begin
        if (reset) begin
            eng_done   <= 1'b0;
            busy       <= 1'b0;
            cnt        <= 5'd0;
            eng_result <= 64'd0;
        end else if (eng_op_clear) begin
            eng_done <= 1'b0;
            busy     <= 1'b0;
        end else if (eng_op_start && !hang) begin
            busy       <= 1'b1;
            cnt        <= 5'd15;
            eng_result <= 64'(eng_a) * 64'(eng_b);
        end else if (busy) begin
            if (cnt == 5'd0) begin
                eng_done <= 1'b1;
                busy     <= 1'b0;
            end else begin
                cnt <= cnt - 5'd1;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard consumer: every ack and response pulse must match the next expected entry.
    always @(negedge clk) begin
        if (!reset) begin
            if (|ack) begin
                if (ack_q.size() == 0) begin
                    check_eq("ack_unexpected", 64'(ack), 64'd0);
                end else begin
                    mon_ack = ack_q.pop_front();
                    check_eq("ack", 64'(ack), 64'(mon_ack));
                    check_eq("op_start_with_ack", 64'(eng_op_start), 64'd1);
                end
            end
            if (|rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    check_eq("rsp_unexpected", 64'(rsp_valid), 64'd0);
                end else begin
                    mon_e = rsp_q.pop_front();
                    check_eq("rsp_valid", 64'(rsp_valid), 64'(mon_e.who));
                    check_eq("rsp_result", rsp_result, mon_e.res);
                    check_eq("rsp_err", 64'(rsp_err), 64'(mon_e.err));
                    check_eq("op_clear_with_rsp", 64'(eng_op_clear), 64'd1);
                    check_eq("eng_a_held", 64'(eng_a), 64'(mon_e.a));
                    check_eq("eng_b_held", 64'(eng_b), 64'(mon_e.b));
                end
            end
        end
    end

    task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    task automatic push_job(input logic [1:0] who, input logic [31:0] a, input logic [31:0] b,
                            input logic err, input logic [63:0] res);
        rsp_t e;
        e.who = who; e.res = res; e.err = err; e.a = a; e.b = b;
        ack_q.push_back(who);
        rsp_q.push_back(e);
    endtask

    // Hold req until n acks are seen (bounded), then drop it.
    task automatic issue(input logic [1:0] v, input int n);
        int got = 0;
        req = v;
        for (int c = 0; c < 300 && got < n; c++) begin
            @(negedge clk);
            if (|ack) got++;
        end
        req = '0;
        check_eq("ack_count", 64'(got), 64'(n));
    endtask

    task automatic drain(input int max);
        for (int c = 0; c < max && (rsp_q.size() != 0 || ack_q.size() != 0); c++) @(negedge clk);
        check_eq("drain", 64'(rsp_q.size() + ack_q.size()), 64'd0);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ack"}, 64'(ack), 64'd0);
        check_eq({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        check_eq({tag, "_rsp_result"}, rsp_result, 64'd0);
        check_eq({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
        check_eq({tag, "_op_start"}, 64'(eng_op_start), 64'd0);
        check_eq({tag, "_op_clear"}, 64'(eng_op_clear), 64'd0);
        check_eq({tag, "_eng_a"}, 64'(eng_a), 64'd0);
        check_eq({tag, "_eng_b"}, 64'(eng_b), 64'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int c;
        reset = 1'b1; req = '0; req_a = '0; req_b = '0; abort = 1'b0; hang = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        reset = 1'b0;
        @(negedge clk);

        // Single job, ack one cycle after req is sampled.
        set_ops(0, 32'd3, 32'd5);
        push_job(2'b01, 32'd3, 32'd5, 1'b0, 64'd15);
        req = 2'b01;
        @(negedge clk);
        check_eq("t1_ack_latency", 64'(ack), 64'h1);
        req = '0;
        drain(60);

        // Both held: strict alternation from rr_ptr=0.
        do_reset();
        set_ops(0, 32'd2, 32'd7);
        set_ops(1, 32'd4, 32'd9);
        push_job(2'b01, 32'd2, 32'd7, 1'b0, 64'd14);
        push_job(2'b10, 32'd4, 32'd9, 1'b0, 64'd36);
        push_job(2'b01, 32'd2, 32'd7, 1'b0, 64'd14);
        push_job(2'b10, 32'd4, 32'd9, 1'b0, 64'd36);
        issue(2'b11, 4);
        drain(200);

        // Hung engine: error response TIMEOUT cycles into WAIT, then recovery.
        hang = 1'b1;
        set_ops(0, 32'd6, 32'd7);
        push_job(2'b01, 32'd6, 32'd7, 1'b1, 64'd0);
        issue(2'b01, 1);
        c = 0;
        while (rsp_valid == '0 && c < 100) begin
            @(negedge clk);
            c++;
        end
        check_eq("t3_timeout_latency", 64'(c), 64'(TIMEOUT + 1));
        drain(10);
        hang = 1'b0;
        set_ops(1, 32'd5, 32'd6);
        push_job(2'b10, 32'd5, 32'd6, 1'b0, 64'd30);
        issue(2'b10, 1);
        drain(60);

        // Abort in the 5th WAIT cycle.
        set_ops(0, 32'd9, 32'd9);
        push_job(2'b01, 32'd9, 32'd9, 1'b1, 64'd0);
        issue(2'b01, 1);
        repeat (5) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_eq("t4_abort_latency", 64'(rsp_valid), 64'h1);
        drain(10);

        // Abort coincident with done: done wins.
        set_ops(1, 32'd11, 32'd13);
        push_job(2'b10, 32'd11, 32'd13, 1'b0, 64'd143);
        issue(2'b10, 1);
        for (int k = 0; k < 40 && !eng_done; k++) @(negedge clk);
        check_eq("t4_done_seen", 64'(eng_done), 64'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        drain(10);

        // Abort outside WAIT is ignored.
        abort = 1'b1;
        set_ops(0, 32'd100, 32'd200);
        push_job(2'b01, 32'd100, 32'd200, 1'b0, 64'd20000);
        issue(2'b01, 1);
        abort = 1'b0;
        drain(60);

        // Reset mid-WAIT with rr_ptr=1 serving requester 0: job lost, rr_ptr back to 0.
        set_ops(0, 32'd21, 32'd2);
        ack_q.push_back(2'b01);
        issue(2'b01, 1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        reset = 1'b0;
        repeat (30) @(negedge clk);
        set_ops(0, 32'd2, 32'd7);
        set_ops(1, 32'd4, 32'd9);
        push_job(2'b01, 32'd2, 32'd7, 1'b0, 64'd14);
        push_job(2'b10, 32'd4, 32'd9, 1'b0, 64'd36);
        issue(2'b11, 2);
        drain(100);

        // Full-width product.
        set_ops(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        push_job(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
        issue(2'b01, 1);
        drain(60);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
        $fatal(1, "watchdog expired");
    end

endmodule
